// File: rtl/cube_move_sequencer_pkg.sv
// Shared types and constants for the cube move sequencer.
package cube_pkg;

    // Widest face index supported (up to 16 faces).
    localparam int unsigned FACE_MAX_W = 4;

    // Fibonacci LFSR taps 16, 14, 13, 11 as a mask over bits [15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic [FACE_MAX_W-1:0] face;
        logic                  ccw;
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_PULSE,
        ST_GAP
    } state_e;

    typedef enum logic [1:0] {
        MODE_SHUF,
        MODE_UNDO,
        MODE_EXT
    } mode_e;

    // Same face turned the other way undoes a move.
    function automatic move_t inverse(input move_t m);
        move_t r;
        r.face = m.face;
        r.ccw  = ~m.ccw;
        return r;
    endfunction

endpackage

// File: rtl/cube_move_sequencer_if.sv
// External move request handshake.
interface cube_move_sequencer_if #(
    parameter int unsigned N_FACES = 6
);
    localparam int unsigned FACE_W = ($clog2(N_FACES) > 1) ? $clog2(N_FACES) : 1;

    logic              mv_valid;
    logic [FACE_W-1:0] mv_face;
    logic              mv_ccw;
    logic              mv_ready;

    modport master (output mv_valid, output mv_face, output mv_ccw, input mv_ready);
    modport slave  (input mv_valid, input mv_face, input mv_ccw, output mv_ready);
endinterface

// File: rtl/cube_move_sequencer_button_debounce.sv
// Synchronises a raw button and emits a 1-cycle event on its debounced rising edge.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_event
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             event_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Accept a level change only after it has held long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
            event_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync2_q == level_q) begin
            cnt_q   <= '0;
            event_q <= 1'b0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
            event_q <= sync2_q;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            event_q <= 1'b0;
        end
    end

    assign btn_event = event_q;

endmodule

// File: rtl/cube_move_sequencer.sv
// Cube move sequencer: shuffle, undo and external moves recorded on a LIFO stack,
// each move driven as a fixed-width one-hot rotation pulse.
module cube_move_sequencer
    import cube_pkg::*;
#(
    parameter int unsigned N_FACES         = 6,
    parameter int unsigned DEPTH           = 32,
    parameter int unsigned PULSE_CYCLES    = 50_000_000,
    parameter int unsigned GAP_CYCLES      = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SHUFFLE_LEN     = 20,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     button1,
    input  logic                     button2,
    cube_move_sequencer_if.slave     mv,
    output logic [N_FACES-1:0]       cw,
    output logic [N_FACES-1:0]       ccw,
    output logic                     shuffle,
    output logic                     retain,
    output logic                     random,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   stack_count
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned REM_W   = $clog2(SHUFFLE_LEN + 1);

    logic ev1;
    logic ev2;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    move_t              ext_q, ext_d;
    logic [PTR_W:0]     sp_q, sp_d;
    logic [N_FACES-1:0] cw_q, cw_d;
    logic [N_FACES-1:0] ccw_q, ccw_d;
    logic               busy_q, busy_d;
    logic               shuffle_q, shuffle_d;
    logic               retain_q, retain_d;
    logic [15:0]        lfsr_q;

    move_t              stack_q [DEPTH];
    move_t              top_mv;
    move_t              shuf_mv;
    move_t              issue_mv;
    logic               push;
    logic               empty;
    logic               full;
    logic               mv_ready_c;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (button1),
        .btn_event(ev1)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (button2),
        .btn_event(ev2)
    );

    assign empty      = (sp_q == '0);
    assign full       = (sp_q == (PTR_W + 1)'(DEPTH));
    assign top_mv     = stack_q[PTR_W'(sp_q - (PTR_W + 1)'(1))];
    assign mv_ready_c = (state_q == ST_IDLE) && !full && !ev1 && !ev2;
    assign mv.mv_ready = mv_ready_c;

    // Free-running LFSR, shifted left with the tap parity entering bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // Random shuffle candidate, never allowed to cancel the previous move.
    always_comb begin
        shuf_mv.face = FACE_MAX_W'(lfsr_q[7:0] % 8'(N_FACES));
        shuf_mv.ccw  = lfsr_q[8];
        if (!empty && (shuf_mv == inverse(top_mv))) shuf_mv.ccw = ~shuf_mv.ccw;
    end

    // Next-state, stack pointer and pulse output logic.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        ext_d    = ext_q;
        sp_d     = sp_q;
        cw_d     = cw_q;
        ccw_d    = ccw_q;
        push     = 1'b0;
        issue_mv = ext_q;

        unique case (state_q)
            ST_IDLE: begin
                cw_d  = '0;
                ccw_d = '0;
                if (ev2 && !empty) begin
                    mode_d  = MODE_UNDO;
                    state_d = ST_ISSUE;
                end else if (ev1 && !full) begin
                    mode_d  = MODE_SHUF;
                    rem_d   = REM_W'(SHUFFLE_LEN);
                    state_d = ST_ISSUE;
                end else if (mv.mv_valid && mv_ready_c) begin
                    mode_d     = MODE_EXT;
                    ext_d.face = FACE_MAX_W'(mv.mv_face);
                    ext_d.ccw  = mv.mv_ccw;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                case (mode_q)
                    MODE_SHUF: begin
                        issue_mv = shuf_mv;
                        push     = 1'b1;
                    end
                    MODE_UNDO: begin
                        issue_mv = inverse(top_mv);
                        sp_d     = sp_q - (PTR_W + 1)'(1);
                    end
                    default: begin
                        issue_mv = ext_q;
                        push     = 1'b1;
                    end
                endcase
                if (push) sp_d = sp_q + (PTR_W + 1)'(1);
                if (issue_mv.ccw) ccw_d = N_FACES'(1) << issue_mv.face;
                else              cw_d  = N_FACES'(1) << issue_mv.face;
                cnt_d   = '0;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
                    cw_d    = '0;
                    ccw_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    case (mode_q)
                        MODE_SHUF: begin
                            rem_d   = rem_q - REM_W'(1);
                            state_d = ((rem_d != '0) && !full) ? ST_ISSUE : ST_IDLE;
                        end
                        MODE_UNDO: state_d = empty ? ST_IDLE : ST_ISSUE;
                        default:   state_d = ST_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        shuffle_d = busy_d && (mode_d == MODE_SHUF);
        retain_d  = (state_d == ST_IDLE) && (sp_d == '0);
    end

    // FSM, counters and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_EXT;
            cnt_q     <= '0;
            rem_q     <= '0;
            ext_q     <= '0;
            sp_q      <= '0;
            cw_q      <= '0;
            ccw_q     <= '0;
            busy_q    <= 1'b0;
            shuffle_q <= 1'b0;
            retain_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            ext_q     <= ext_d;
            sp_q      <= sp_d;
            cw_q      <= cw_d;
            ccw_q     <= ccw_d;
            busy_q    <= busy_d;
            shuffle_q <= shuffle_d;
            retain_q  <= retain_d;
        end
    end

    // Move stack storage; contents are only meaningful below the pointer.
    always_ff @(posedge clk) begin
        if (push) stack_q[PTR_W'(sp_q)] <= issue_mv;
    end

    assign cw          = cw_q;
    assign ccw         = ccw_q;
    assign busy        = busy_q;
    assign shuffle     = shuffle_q;
    assign retain      = retain_q;
    assign random      = lfsr_q[0];
    assign stack_count = sp_q;

endmodule

// File: tb/tb_cube_move_sequencer.sv
// Self-checking bench for cube_move_sequencer with a queue-based move model.
module tb_cube_move_sequencer;
    localparam int NF    = 6;
    localparam int DEPTH = 8;
    localparam int PULSE = 4;
    localparam int GAP   = 2;
    localparam int DEB   = 8;
    localparam int SLEN  = 5;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          button1 = 1'b0;
    logic          button2 = 1'b0;
    logic [NF-1:0] cw, ccw;
    logic          shuffle, retain, random, busy;
    logic [3:0]    stack_count;

    int n_chk = 0;
    int n_pass = 0;

    cube_move_sequencer_if #(.N_FACES(NF)) mv_if ();

    cube_move_sequencer #(
        .N_FACES(NF), .DEPTH(DEPTH), .PULSE_CYCLES(PULSE), .GAP_CYCLES(GAP),
        .DEBOUNCE_CYCLES(DEB), .SHUFFLE_LEN(SLEN), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .button1(button1), .button2(button2), .mv(mv_if),
        .cw(cw), .ccw(ccw), .shuffle(shuffle), .retain(retain), .random(random),
        .busy(busy), .stack_count(stack_count)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, new bit enters at the bottom.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else m_lfsr <= 16'((m_lfsr << 1) | (m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]));
    end

    // Model stack of recorded moves, encoded face*2 + ccw.
    int ms[$];

    // Pulse monitor: records each observed move, its length, start cycle and the LFSR at issue.
    int          cyc = 0;
    int          p_face[$], p_dir[$], p_len[$], p_start[$];
    logic [15:0] p_iss[$];
    logic [15:0] prev_l;
    logic        active = 1'b0;
    int          cur_len, onehot_err, shuf_cyc, mon_f;
    always @(negedge clk) begin
        cyc++;
        if ($countones(cw) + $countones(ccw) > 1) onehot_err++;
        if (shuffle) shuf_cyc++;
        if ((cw | ccw) != '0) begin
            if (!active) begin
                active = 1'b1;
                cur_len = 0;
                mon_f = -1;
                for (int i = 0; i < NF; i++) if (cw[i] | ccw[i]) mon_f = i;
                p_face.push_back(mon_f);
                p_dir.push_back((ccw != '0) ? 1 : 0);
                p_start.push_back(cyc);
                p_iss.push_back(prev_l);
            end
            cur_len++;
        end else if (active) begin
            active = 1'b0;
            p_len.push_back(cur_len);
        end
        prev_l = m_lfsr;
    end

    task automatic clear_mon();
        @(posedge clk);
        p_face.delete(); p_dir.delete(); p_len.delete(); p_start.delete(); p_iss.delete();
        onehot_err = 0;
        shuf_cyc = 0;
    endtask

    task automatic press(input int which, input int n);
        @(negedge clk);
        if (which == 1) button1 = 1'b1; else button2 = 1'b1;
        repeat (n) @(negedge clk);
        button1 = 1'b0;
        button2 = 1'b0;
    endtask

    task automatic wait_busy(input logic want, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (busy === want) ok = 1'b1;
        end
    endtask

    task automatic do_ext(input int f, input int d, output bit acc);
        acc = 1'b0;
        @(negedge clk);
        mv_if.mv_valid = 1'b1;
        mv_if.mv_face  = 3'(f);
        mv_if.mv_ccw   = d[0];
        for (int i = 0; i < 10 && !acc; i++) begin
            if (mv_if.mv_ready === 1'b1) acc = 1'b1;
            @(negedge clk);
        end
        mv_if.mv_valid = 1'b0;
    endtask

    task automatic test_reset();
        mv_if.mv_valid = 1'b0; mv_if.mv_face = '0; mv_if.mv_ccw = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (random !== SEED[0]) $display("FAIL reset_random: got %0b want %0b", random, SEED[0]); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (retain !== 1'b1) $display("FAIL reset_retain: got %0b want 1", retain); else n_pass++;
        n_chk++; if (busy !== 1'b0 || shuffle !== 1'b0) $display("FAIL reset_busy: busy %0b shuffle %0b want 0 0", busy, shuffle); else n_pass++;
        n_chk++; if (cw !== '0 || ccw !== '0) $display("FAIL reset_pulses: cw %b ccw %b want 0", cw, ccw); else n_pass++;
        n_chk++; if (stack_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", stack_count); else n_pass++;
        n_chk++; if (mv_if.mv_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", mv_if.mv_ready); else n_pass++;
        n_chk++; if (random !== m_lfsr[0]) $display("FAIL lfsr_track: got %0b want %0b", random, m_lfsr[0]); else n_pass++;
    endtask

    task automatic test_shuffle();
        bit ok;
        int bad = 0;
        int ef, ed;
        logic [15:0] iss;
        clear_mon();
        press(1, 12);
        wait_busy(1'b1, 20, ok);
        if (ok) wait_busy(1'b0, 200, ok);
        n_chk++; if (!ok) $display("FAIL shuf_timeout: busy did not finish"); else n_pass++;
        n_chk++; if (p_face.size() != SLEN) $display("FAIL shuf_moves: got %0d want %0d", p_face.size(), SLEN); else n_pass++;
        for (int i = 0; i < p_face.size() && i < SLEN; i++) begin
            iss = p_iss[i];
            ef = int'(iss[7:0]) % NF;
            ed = int'(iss[8]);
            if (ms.size() > 0 && ms[$] == ef * 2 + (1 - ed)) ed = 1 - ed;
            if (p_face[i] != ef || p_dir[i] != ed) bad++;
            if (i >= p_len.size() || p_len[i] != PULSE) bad++;
            if (i > 0 && p_start[i] - p_start[i-1] != 1 + PULSE + GAP) bad++;
            if (i > 0 && p_face[i] == p_face[i-1] && p_dir[i] != p_dir[i-1]) bad++;
            ms.push_back(ef * 2 + ed);
        end
        n_chk++; if (bad != 0) $display("FAIL shuf_seq: %0d bad move/timing items, want 0", bad); else n_pass++;
        n_chk++; if (shuf_cyc != SLEN * (1 + PULSE + GAP)) $display("FAIL shuf_flag: high %0d cycles want %0d", shuf_cyc, SLEN * (1 + PULSE + GAP)); else n_pass++;
        n_chk++; if (stack_count !== 4'(SLEN)) $display("FAIL shuf_count: got %0d want %0d", stack_count, SLEN); else n_pass++;
        n_chk++; if (retain !== 1'b0) $display("FAIL shuf_retain: got %0b want 0", retain); else n_pass++;
        n_chk++; if (onehot_err != 0) $display("FAIL shuf_onehot: %0d cycles with >1 bit", onehot_err); else n_pass++;
        n_chk++; if (random !== m_lfsr[0]) $display("FAIL shuf_random: got %0b want %0b", random, m_lfsr[0]); else n_pass++;
    endtask

    task automatic test_undo();
        bit ok;
        int bad = 0;
        int n = ms.size();
        clear_mon();
        press(2, 12);
        wait_busy(1'b1, 20, ok);
        press(1, 12);
        if (ok) wait_busy(1'b0, 200, ok);
        repeat (20) @(negedge clk);
        n_chk++; if (!ok || busy !== 1'b0) $display("FAIL undo_timeout: ok %0b busy %0b want 1 0", ok, busy); else n_pass++;
        n_chk++; if (p_face.size() != n) $display("FAIL undo_moves: got %0d want %0d", p_face.size(), n); else n_pass++;
        for (int i = 0; i < n && i < p_face.size(); i++) begin
            if (p_face[i] != ms[n-1-i] / 2 || p_dir[i] != 1 - ms[n-1-i] % 2) bad++;
            if (i >= p_len.size() || p_len[i] != PULSE) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL undo_seq: %0d bad items, want 0", bad); else n_pass++;
        n_chk++; if (stack_count !== 4'd0) $display("FAIL undo_count: got %0d want 0", stack_count); else n_pass++;
        n_chk++; if (retain !== 1'b1) $display("FAIL undo_retain: got %0b want 1", retain); else n_pass++;
        ms.delete();
    endtask

    task automatic test_glitch();
        repeat (20) @(negedge clk);
        clear_mon();
        press(1, 5);
        repeat (30) @(negedge clk);
        n_chk++; if (p_face.size() != 0 || busy !== 1'b0) $display("FAIL glitch: %0d moves busy %0b want 0 0", p_face.size(), busy); else n_pass++;
        n_chk++; if (stack_count !== 4'd0 || retain !== 1'b1) $display("FAIL glitch_state: count %0d retain %0b want 0 1", stack_count, retain); else n_pass++;
    endtask

    task automatic test_ext();
        bit acc, ok;
        int bad = 0;
        int f, d, k;
        clear_mon();
        do_ext(2, 1, acc);
        wait_busy(1'b0, 40, ok);
        n_chk++; if (!acc || !ok) $display("FAIL ext_accept: acc %0b ok %0b want 1 1", acc, ok); else n_pass++;
        n_chk++; if (p_face.size() != 1 || p_face[0] != 2 || p_dir[0] != 1 || p_len[0] != PULSE)
            $display("FAIL ext_ccw2: %0d moves, first face/dir/len not 2/1/%0d", p_face.size(), PULSE); else n_pass++;
        ms.push_back(2 * 2 + 1);
        k = 1;
        while (ms.size() < DEPTH && k < 20) begin
            f = $urandom_range(NF - 1, 0);
            d = $urandom_range(1, 0);
            do_ext(f, d, acc);
            wait_busy(1'b0, 40, ok);
            if (!acc || !ok) bad++;
            if (p_face.size() != k + 1) bad++;
            else if (p_face[k] != f || p_dir[k] != d || p_len[k] != PULSE) bad++;
            ms.push_back(f * 2 + d);
            k++;
        end
        n_chk++; if (bad != 0) $display("FAIL ext_random: %0d bad moves, want 0", bad); else n_pass++;
        n_chk++; if (stack_count !== 4'(DEPTH)) $display("FAIL ext_full_count: got %0d want %0d", stack_count, DEPTH); else n_pass++;
        n_chk++; if (mv_if.mv_ready !== 1'b0) $display("FAIL full_ready: got %0b want 0", mv_if.mv_ready); else n_pass++;
        k = p_face.size();
        press(1, 12);
        do_ext(1, 0, acc);
        repeat (20) @(negedge clk);
        n_chk++; if (acc || p_face.size() != k || stack_count !== 4'(DEPTH))
            $display("FAIL full_block: acc %0b moves %0d count %0d want 0 %0d %0d", acc, p_face.size(), stack_count, k, DEPTH); else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        bit ok = 1'b0;
        int k;
        @(negedge clk);
        button2 = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((cw | ccw) != '0) ok = 1'b1;
        end
        n_chk++; if (!ok) $display("FAIL rst_pulse_start: no pulse seen"); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        button2 = 1'b0;
        #1;
        n_chk++; if (cw !== '0 || ccw !== '0 || busy !== 1'b0) $display("FAIL rst_async: cw %b ccw %b busy %0b want 0", cw, ccw, busy); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (stack_count !== 4'd0 || retain !== 1'b1) $display("FAIL rst_clear: count %0d retain %0b want 0 1", stack_count, retain); else n_pass++;
        k = p_face.size();
        repeat (15) @(negedge clk);
        n_chk++; if (p_face.size() != k || cw !== '0 || ccw !== '0 || busy !== 1'b0)
            $display("FAIL rst_no_resume: moves %0d->%0d busy %0b want none", k, p_face.size(), busy); else n_pass++;
        n_chk++; if (random !== m_lfsr[0]) $display("FAIL rst_random: got %0b want %0b", random, m_lfsr[0]); else n_pass++;
        ms.delete();
    endtask

    initial begin
        onehot_err = 0;
        shuf_cyc = 0;
        test_reset();
        test_shuffle();
        test_undo();
        test_glitch();
        test_ext();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
